// File: rtl/view_packer.sv
// Byte-serial to 128-bit word packer, first byte in the top lane. The output
// sits in a one-word holding slot; flush publishes a zero-padded partial word.
module view_packer #(
  parameter int BYTE_W    = 8,
  parameter int NUM_BYTES = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 inValid,
  output logic                                 inReady,
  input  logic [BYTE_W-1:0]                    byteIn,
  input  logic                                 flush,
  output logic                                 outValid,
  input  logic                                 outReady,
  output logic [BYTE_W*NUM_BYTES-1:0]          wordOut,
  output logic [$clog2(NUM_BYTES+1)-1:0]       wordBytes
);

  localparam int WORD_W = BYTE_W * NUM_BYTES;
  localparam int CNT_W  = $clog2(NUM_BYTES + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(NUM_BYTES);

  logic [WORD_W-1:0] r_fill;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_flush_pend;
  logic [WORD_W-1:0] r_word;
  logic [CNT_W-1:0]  r_bytes;
  logic              r_out_valid;

  logic              w_accept;
  logic              w_slot_free;
  logic [WORD_W-1:0] w_fill_next;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              w_full;
  logic              w_flush_req;
  logic              w_publish;

  assign inReady     = (r_cnt != FULL) && !r_flush_pend;
  assign w_accept    = inValid && inReady;
  assign w_slot_free = !r_out_valid || outReady;

  // The byte accepted this edge is folded in before full/flush decisions.
  always_comb begin
    w_fill_next = r_fill;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (w_accept && (r_cnt == CNT_W'(i)))
        w_fill_next[(NUM_BYTES-1-i)*BYTE_W +: BYTE_W] = byteIn;
    end
  end

  assign w_cnt_next  = r_cnt + {{(CNT_W-1){1'b0}}, w_accept};
  assign w_full      = (w_cnt_next == FULL);
  assign w_flush_req = (flush || r_flush_pend) && (w_cnt_next != '0) && !w_full;
  assign w_publish   = w_slot_free && (w_full || w_flush_req);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fill       <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
      r_word       <= '0;
      r_bytes      <= '0;
      r_out_valid  <= 1'b0;
    end else if (w_publish) begin
      r_word       <= w_fill_next;
      r_bytes      <= w_cnt_next;
      r_out_valid  <= 1'b1;
      r_fill       <= '0;
      r_cnt        <= '0;
      r_flush_pend <= 1'b0;
    end else begin
      r_fill <= w_fill_next;
      r_cnt  <= w_cnt_next;
      if (r_out_valid && outReady)
        r_out_valid <= 1'b0;
      // A blocked flush keeps input closed until the slot frees up.
      if (w_flush_req)
        r_flush_pend <= 1'b1;
    end
  end

  assign outValid  = r_out_valid;
  assign wordOut   = r_word;
  assign wordBytes = r_bytes;

endmodule

// File: tb/tb_view_packer.sv
// Bench for view_packer: directed vector table, hand-written corner sequences,
// then random traffic against a queue-based reference model.
module tb_view_packer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         inValid = 1'b0;
  logic         inReady;
  logic [7:0]   byteIn = '0;
  logic         flush = 1'b0;
  logic         outValid;
  logic         outReady = 1'b0;
  logic [127:0] wordOut;
  logic [4:0]   wordBytes;

  int n_checks = 0;
  int n_err    = 0;

  view_packer #(.BYTE_W(8), .NUM_BYTES(16)) dut (
    .clk(clk), .rst(rst), .inValid(inValid), .inReady(inReady),
    .byteIn(byteIn), .flush(flush), .outValid(outValid),
    .outReady(outReady), .wordOut(wordOut), .wordBytes(wordBytes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         v;
    logic [7:0]   b;
    logic         fl;
    logic         ordy;
    logic         e_rdy;
    logic         e_ov;
    logic [4:0]   e_wb;
    logic [127:0] e_word;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic v, logic [7:0] b, logic fl, logic ordy,
                              logic e_rdy, logic e_ov, logic [4:0] e_wb,
                              logic [127:0] e_word);
    vec_t r;
    r.v = v; r.b = b; r.fl = fl; r.ordy = ordy;
    r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_wb = e_wb; r.e_word = e_word;
    return r;
  endfunction

  // Word made of 16 consecutive byte values starting at base, first at the top.
  function automatic logic [127:0] seq_word(logic [7:0] base);
    logic [127:0] w = '0;
    logic [7:0]   b;
    for (int i = 0; i < 16; i++) begin
      b = base + 8'(i);
      w = {w[119:0], b};
    end
    return w;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] b, input logic fl, input logic ordy);
    inValid = v; byteIn = b; flush = fl; outReady = ordy;
  endtask

  task automatic do_reset();
    drive(0, 8'h00, 0, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic feed16(input logic [7:0] base, input logic ordy);
    for (int i = 0; i < 16; i++) begin
      drive(1, base + 8'(i), 0, ordy);
      tick();
    end
    drive(0, 8'h00, 0, ordy);
  endtask

  // Reference model state: pending bytes as a queue, plus the output slot.
  logic [7:0]   m_q[$];
  logic         m_pend;
  logic         m_ov;
  logic [127:0] m_word;
  logic [4:0]   m_n;

  function automatic logic [127:0] pack_q();
    logic [127:0] w = '0;
    for (int i = 0; i < m_q.size(); i++)
      w = w | (128'(m_q[i]) << (8 * (15 - i)));
    return w;
  endfunction

  logic [127:0] W1, WF, WB;
  int accepted;

  initial begin
    W1 = seq_word(8'h00);
    WF = {40'hA1A2A3A4A5, 88'h0};
    WB = {8'hB0, 120'h0};

    // Directed table: full word, flush of a partial word, first byte after flush.
    for (int i = 0; i < 16; i++)
      tbl.push_back(mk(1, 8'(i), 0, 1, 1, (i == 15), (i == 15) ? 5'd16 : 5'd0,
                       (i == 15) ? W1 : 128'h0));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 5'd16, W1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 8'hA1 + 8'(i), 0, 1, 1, 0, 5'd16, W1));
    tbl.push_back(mk(1, 8'hA5, 1, 1, 1, 1, 5'd5, WF));
    tbl.push_back(mk(1, 8'hB0, 0, 1, 1, 0, 5'd5, WF));
    tbl.push_back(mk(0, 8'h00, 1, 1, 1, 1, 5'd1, WB));
    tbl.push_back(mk(0, 8'h00, 0, 1, 1, 0, 5'd1, WB));

    do_reset();
    chk("reset_inReady", 128'(inReady), 128'd1);
    chk("reset_outValid", 128'(outValid), 128'd0);
    chk("reset_wordOut", wordOut, 128'd0);
    chk("reset_wordBytes", 128'(wordBytes), 128'd0);

    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].b, tbl[k].fl, tbl[k].ordy);
      chk($sformatf("tbl%0d_inReady", k), 128'(inReady), 128'(tbl[k].e_rdy));
      tick();
      chk($sformatf("tbl%0d_outValid", k), 128'(outValid), 128'(tbl[k].e_ov));
      chk($sformatf("tbl%0d_wordBytes", k), 128'(wordBytes), 128'(tbl[k].e_wb));
      chk($sformatf("tbl%0d_wordOut", k), wordOut, tbl[k].e_word);
    end

    // Backpressure: 40 bytes offered with the consumer stalled.
    do_reset();
    accepted = 0;
    for (int k = 0; k < 40; k++) begin
      drive(1, 8'(accepted), 0, 0);
      if (inReady) accepted++;
      tick();
    end
    chk("bp_accepted", 128'(accepted), 128'd32);
    chk("bp_inReady_low", 128'(inReady), 128'd0);
    chk("bp_held_valid", 128'(outValid), 128'd1);
    chk("bp_held_word", wordOut, seq_word(8'h00));
    drive(0, 8'h00, 0, 1);
    tick();
    chk("bp_word2_valid", 128'(outValid), 128'd1);
    chk("bp_word2", wordOut, seq_word(8'h10));
    chk("bp_word2_bytes", 128'(wordBytes), 128'd16);
    chk("bp_inReady_back", 128'(inReady), 128'd1);
    feed16(8'h20, 1);
    chk("bp_resume_valid", 128'(outValid), 128'd1);
    chk("bp_resume_word", wordOut, seq_word(8'h20));

    // Flush while the slot is blocked.
    do_reset();
    feed16(8'h40, 0);
    chk("bf_held_valid", 128'(outValid), 128'd1);
    drive(1, 8'hC1, 0, 0); tick();
    drive(1, 8'hC2, 0, 0); tick();
    drive(1, 8'hC3, 1, 0); tick();
    chk("bf_inReady_pend1", 128'(inReady), 128'd0);
    drive(1, 8'hEE, 0, 0); tick();
    chk("bf_inReady_pend2", 128'(inReady), 128'd0);
    chk("bf_still_held", wordOut, seq_word(8'h40));
    drive(0, 8'h00, 0, 1); tick();
    chk("bf_pub_valid", 128'(outValid), 128'd1);
    chk("bf_pub_bytes", 128'(wordBytes), 128'd3);
    chk("bf_pub_word", wordOut, {24'hC1C2C3, 104'h0});
    chk("bf_inReady_back", 128'(inReady), 128'd1);
    tick();
    chk("bf_drained", 128'(outValid), 128'd0);

    // Asynchronous reset in the middle of a fill, with a word held at the output.
    do_reset();
    feed16(8'h60, 0);
    for (int i = 0; i < 7; i++) begin
      drive(1, 8'hE0 + 8'(i), 0, 0);
      tick();
    end
    drive(0, 8'h00, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_valid", 128'(outValid), 128'd0);
    chk("rst_async_word", wordOut, 128'd0);
    chk("rst_async_bytes", 128'(wordBytes), 128'd0);
    chk("rst_async_inReady", 128'(inReady), 128'd1);
    #1 rst = 1'b0;
    feed16(8'h50, 1);
    chk("rst_fresh_valid", 128'(outValid), 128'd1);
    chk("rst_fresh_word", wordOut, seq_word(8'h50));

    // Consume and reload on the same edge.
    do_reset();
    feed16(8'h70, 0);
    for (int i = 0; i < 15; i++) begin
      drive(1, 8'h80 + 8'(i), 0, 0);
      tick();
    end
    chk("cr_before_word", wordOut, seq_word(8'h70));
    drive(1, 8'h8F, 0, 1); tick();
    chk("cr_valid_kept", 128'(outValid), 128'd1);
    chk("cr_new_word", wordOut, seq_word(8'h80));
    drive(0, 8'h00, 0, 1); tick();
    chk("cr_drained", 128'(outValid), 128'd0);

    // Random traffic against the reference model.
    do_reset();
    m_q.delete(); m_pend = 0; m_ov = 0; m_word = '0; m_n = '0;
    for (int c = 0; c < 3000; c++) begin
      logic v, fl, ordy, rdy, acc, free, complete, want_flush;
      logic [7:0] b;
      v    = ($urandom_range(0, 9) < 8);
      fl   = ($urandom_range(0, 9) == 0);
      ordy = ($urandom_range(0, 9) < 6);
      b    = 8'($urandom);
      drive(v, b, fl, ordy);
      rdy = (m_q.size() < 16) && !m_pend;
      chk("rnd_inReady", 128'(inReady), 128'(rdy));
      acc = v && rdy;
      if (acc) m_q.push_back(b);
      free = !m_ov || ordy;
      if (m_ov && ordy) m_ov = 0;
      complete   = (m_q.size() == 16);
      want_flush = (fl || m_pend) && (m_q.size() > 0) && !complete;
      if (free && (complete || want_flush)) begin
        m_word = pack_q();
        m_n    = 5'(m_q.size());
        m_ov   = 1;
        m_q.delete();
        m_pend = 0;
      end else if (want_flush) begin
        m_pend = 1;
      end
      tick();
      chk("rnd_outValid", 128'(outValid), 128'(m_ov));
      chk("rnd_wordOut", wordOut, m_word);
      chk("rnd_wordBytes", 128'(wordBytes), 128'(m_n));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
